// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between two byte requesters.
// Accepts a byte, holds enable until the transmitter reports sending,
// waits for the frame to finish, then enforces an inter-frame gap.
module uart_tx_arbiter #(
    parameter int GAP_CYCLES    = 2,
    parameter int START_TIMEOUT = 16
) (
    input  logic       baud_clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_parity,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_parity,
    output logic       req1_ready,
    output logic [7:0] tx_din,
    output logic       tx_parity_bit,
    output logic       tx_enable,
    input  logic       tx_sending,
    output logic       busy,
    output logic       grant_id,
    output logic       timeout_err
);

    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam int TW = $clog2(START_TIMEOUT) + 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TO_LAST  = TW'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_GAP} state_t;

    state_t        state_q;
    logic          rr_ptr_q;
    logic [GW-1:0] gap_cnt_q;
    logic [TW-1:0] to_cnt_q;
    logic [7:0]    tx_din_q;
    logic          tx_parity_q;
    logic          tx_enable_q;
    logic          busy_q;
    logic          grant_id_q;
    logic          timeout_err_q;

    logic grant_ok;
    logic win1;
    logic accept;

    // Grant only from IDLE, and never while a frame (possibly one left over
    // from before a reset) is still on the line. On contention rr_ptr picks.
    assign grant_ok   = (state_q == S_IDLE) && !tx_sending;
    assign win1       = req1_valid && (!req0_valid || rr_ptr_q);
    assign req0_ready = grant_ok && req0_valid && !win1;
    assign req1_ready = grant_ok && win1;
    assign accept     = req0_ready || req1_ready;

    assign tx_din        = tx_din_q;
    assign tx_parity_bit = tx_parity_q;
    assign tx_enable     = tx_enable_q;
    assign busy          = busy_q;
    assign grant_id      = grant_id_q;
    assign timeout_err   = timeout_err_q;

    // Arbitration FSM with all outputs registered alongside the state.
    always_ff @(posedge baud_clk) begin
        timeout_err_q <= 1'b0;
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= 1'b0;
            gap_cnt_q   <= '0;
            to_cnt_q    <= '0;
            tx_din_q    <= 8'h00;
            tx_parity_q <= 1'b0;
            tx_enable_q <= 1'b0;
            busy_q      <= 1'b0;
            grant_id_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        tx_din_q    <= win1 ? req1_data : req0_data;
                        tx_parity_q <= win1 ? req1_parity : req0_parity;
                        grant_id_q  <= win1;
                        rr_ptr_q    <= ~win1;
                        tx_enable_q <= 1'b1;
                        busy_q      <= 1'b1;
                        to_cnt_q    <= '0;
                        state_q     <= S_START;
                    end
                end
                S_START: begin
                    // A rise on the last allowed cycle still counts as a start.
                    if (tx_sending) begin
                        tx_enable_q <= 1'b0;
                        state_q     <= S_BUSY;
                    end else if (to_cnt_q == TO_LAST) begin
                        // Transmitter never answered: drop the byte.
                        tx_enable_q   <= 1'b0;
                        timeout_err_q <= 1'b1;
                        gap_cnt_q     <= '0;
                        if (GAP_CYCLES == 0) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_GAP;
                        end
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                    end
                end
                S_BUSY: begin
                    if (!tx_sending) begin
                        gap_cnt_q <= '0;
                        if (GAP_CYCLES == 0) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    tx_enable_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter between two byte requesters (req0, req1) using round-robin arbitration.
- Per byte: accepts it via a valid/ready handshake, latches data and parity bit, and drives the transmitter's din/enable/parity_bit inputs.
- Tracks the transmitter's sending flag to detect start and end of a frame, then enforces an inter-frame gap.
- Runs in the baud clock domain, between byte producers (command/response logic) and uart_tx.

Parameters:
GAP_CYCLES, 2, idle baud_clk cycles inserted after sending falls before next grant (0 allowed)
START_TIMEOUT, 16, max cycles in START waiting for tx_sending to rise before abort (>=1)

Ports:
baud_clk  input  1  clock, same clock as uart_tx
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has a byte
req0_data  input  8  requester 0 byte
req0_parity  input  1  parity_bit value for requester 0 byte
req0_ready  output  1  requester 0 byte accepted this cycle
req1_valid  input  1  requester 1 has a byte
req1_data  input  8  requester 1 byte
req1_parity  input  1  parity_bit value for requester 1 byte
req1_ready  output  1  requester 1 byte accepted this cycle
tx_din  output  8  to uart_tx din
tx_parity_bit  output  1  to uart_tx parity_bit
tx_enable  output  1  to uart_tx enable
tx_sending  input  1  from uart_tx sending
busy  output  1  high whenever state != IDLE
grant_id  output  1  requester owning the current or last transfer
timeout_err  output  1  one-cycle pulse on START abort

Behaviour:
- Clock and reset: one clock, baud_clk. reset is synchronous and active-high.
- Reset values:
  - state=IDLE, rr_ptr=0 (req0 has priority).
  - tx_din=0, tx_parity_bit=0, tx_enable=0.
  - busy=0, grant_id=0, timeout_err=0.
  - Gap and timeout counters = 0.
- Registered outputs: tx_*, busy, grant_id, timeout_err. reqN_ready is combinational from state, valid and rr_ptr.
- IDLE:
  - If exactly one reqN_valid=1, that requester wins.
  - If both are valid, the requester equal to rr_ptr wins.
  - Winner's ready=1 in that cycle only. Transfer = valid && ready.
  - On transfer: latch data into tx_din and parity into tx_parity_bit; set grant_id=winner; rr_ptr=~winner; next state START.
  - The loser's ready=0. Its valid must be held; it is served on the next grant.
  - reqN_ready=0 in every state other than IDLE.
- START:
  - tx_enable=1, held at level until tx_sending is sampled 1.
  - Latency: first cycle of tx_enable=1 is the cycle after acceptance.
  - On tx_sending=1: next state BUSY, tx_enable=0 from that edge.
  - Timeout counter counts START cycles. If START_TIMEOUT cycles elapse with tx_sending=0:
    - tx_enable=0 and timeout_err=1 for one cycle.
    - Byte is dropped; next state GAP.
- BUSY:
  - tx_enable=0; tx_din and tx_parity_bit stable.
  - On tx_sending=0: next state GAP, or IDLE if GAP_CYCLES=0.
- GAP:
  - Counts GAP_CYCLES cycles, then IDLE. Counter clears on entry.
  - No acceptance during GAP.
- tx_din and tx_parity_bit hold their last value in IDLE; they change only on acceptance.
- Counter wrap: counters saturate at their terminal value. Widths use clog2 of the parameter + 1 and never wrap.
- Reset mid-operation (any state):
  - Return to IDLE and rr_ptr=0 at the next edge; tx_enable=0; byte in flight is discarded.
  - A frame already started inside uart_tx is not this block's concern.
  - After reset, a still-high tx_sending is waited out: IDLE does not grant while tx_sending=1.
- Simultaneous events:
  - tx_sending rising on the timeout's last cycle counts as success (BUSY); no timeout_err.
  - A requester's valid dropping in the same cycle as arbitration: only valid requesters are considered.
- Valid held during busy: requesters are not accepted and no data is captured.

Test Plan:
- Single byte: reset 3 cycles; req0_valid=1, data=0xA5, parity=1; uart_tx model raises sending 2 cycles after enable for 11 cycles -> req0_ready pulse 1 cycle; tx_din=0xA5, tx_parity_bit=1; tx_enable high exactly until sending sampled; busy clears GAP_CYCLES=2 cycles after sending falls.
- Contention: req0=0x11 and req1=0x22 both valid from reset release, held -> order 0x11, 0x22, 0x11, 0x22; grant_id toggles 0,1,0,1; no ready while busy.
- Back-to-back single requester: req1 streams 0x01..0x04 -> each accepted first IDLE cycle after gap; exactly 2 idle cycles between sending falling and next tx_enable rising.
- Timeout: tx_sending tied 0; req0 sends 0x5A -> tx_enable high 16 cycles, then low; timeout_err one-cycle pulse; busy returns 0 after gap; next byte still accepted.
- Reset mid-BUSY: assert reset while sending=1 -> next edge: tx_enable=0, busy=0, rr_ptr=0; no grant until sending falls.
- GAP_CYCLES=0 build: same as single byte -> IDLE the cycle after sending falls; next byte's tx_enable starts 2 cycles after sending falls.
